waveform_averager: RTL and testbench

- Consumes the sign-extended 32-bit single-channel sample stream produced by the channel splitter, one instance per ADC channel.
- On each trigger it accumulates NSAMPLES consecutive valid samples into an on-chip sum buffer, element-wise, and repeats for NAVERAGES triggers.
- When the last pass completes, it streams the raw sums out over AXI-Stream with backpressure; software performs the divide.

---
 rtl/waveform_averager.sv | 195 +++++++++++++++++++
 tb/tb_waveform_averager.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_averager.sv
// waveform_averager
//   Accumulates NAVERAGES triggered records of NSAMPLES samples into an on-chip
//   sum buffer, then streams the raw sums out over AXI-Stream.
// Ports:
//   aclk, rst            clock, synchronous active-high reset
//   start                pulse that arms a run (ignored unless idle)
//   trigger              record start marker, aligned with the sample stream
//   nsamples, naverages  run geometry, captured on start
//   S_AXIS_tdata/tvalid  signed input samples (no backpressure)
//   M_AXIS_tdata/tvalid/tready/tlast  sum output stream
//   busy, done           run status
module waveform_averager #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 10,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        trigger,
  input  logic [ADDR_WIDTH:0]         nsamples,
  input  logic [CNT_WIDTH-1:0]        naverages,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic                        busy,
  output logic                        done
);
  localparam int IW = ADDR_WIDTH + 1;
  localparam int DW = AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACQ, S_DUMP} state_t;
  state_t state_reg, state_next;

  logic [IW-1:0]         nsamples_reg;
  logic [CNT_WIDTH-1:0]  naverages_reg;
  logic [CNT_WIDTH-1:0]  pass_reg;
  logic [IW-1:0]         idx_reg;

  // Accumulate pipeline: stage registers feeding the write one cycle after the read.
  logic                  wr_pending_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [DW-1:0]         wr_sample_reg;
  logic                  wr_first_reg;
  logic                  wr_last_reg;

  // Sum buffer with registered read.
  logic [DW-1:0]         mem [0:(1<<ADDR_WIDTH)-1];
  logic [DW-1:0]         rd_data_reg;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DW-1:0]         wr_data;

  // Dump path: read pointer, in-flight read, skid and output registers.
  logic [IW-1:0]         rd_ptr_reg;
  logic                  inflight_reg, inflight_last_reg;
  logic                  skid_valid_reg, skid_last_reg;
  logic [DW-1:0]         skid_data_reg;
  logic                  out_valid_reg, out_last_reg;
  logic [DW-1:0]         out_data_reg;
  logic                  done_reg;

  logic                  start_ok, start_noop, arm_hit, acc_en, acc_last;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  pass_end, final_pass, pop, issue;
  logic [1:0]            occ;

  always_comb begin
    start_ok   = (state_reg == S_IDLE) && start && (nsamples != '0) && (naverages != '0);
    start_noop = (state_reg == S_IDLE) && start && ((nsamples == '0) || (naverages == '0));
    arm_hit    = (state_reg == S_ARM) && trigger;
    // Samples past the end of the record are dropped while the last write drains.
    acc_en     = (arm_hit && S_AXIS_tvalid) ||
                 ((state_reg == S_ACQ) && S_AXIS_tvalid && (idx_reg < nsamples_reg));
    acc_addr   = (state_reg == S_ARM) ? '0 : idx_reg[ADDR_WIDTH-1:0];
    acc_last   = (state_reg == S_ARM) ? (nsamples_reg == IW'(1))
                                      : (idx_reg == nsamples_reg - IW'(1));
    pass_end   = wr_pending_reg && wr_last_reg;
    final_pass = (pass_reg + CNT_WIDTH'(1)) == naverages_reg;
    wr_data    = wr_first_reg ? wr_sample_reg : rd_data_reg + wr_sample_reg;
    pop        = out_valid_reg && M_AXIS_tready;
    occ        = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(inflight_reg);
    // Keep at most two words queued (output + skid) counting the read in flight.
    issue      = (state_reg == S_DUMP) && (rd_ptr_reg < nsamples_reg) &&
                 ((occ < 2'd2) || ((occ == 2'd2) && pop));
    rd_addr    = (state_reg == S_DUMP) ? rd_ptr_reg[ADDR_WIDTH-1:0] : acc_addr;
  end

  // FSM: state register
  always_ff @(posedge aclk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_ok) state_next = S_ARM;
      S_ARM:  if (trigger)  state_next = S_ACQ;
      S_ACQ:  if (pass_end) state_next = final_pass ? S_DUMP : S_ARM;
      S_DUMP: if (pop && out_last_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy          = (state_reg != S_IDLE);
    done          = done_reg;
    M_AXIS_tvalid = out_valid_reg;
    M_AXIS_tlast  = out_valid_reg && out_last_reg;
    M_AXIS_tdata  = out_data_reg;
  end

  // Sum buffer; the accumulate read and write never target the same address
  // in the same cycle because records advance one address per sample.
  always_ff @(posedge aclk) begin
    if (wr_pending_reg) mem[wr_addr_reg] <= wr_data;
    rd_data_reg <= mem[rd_addr];
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      nsamples_reg      <= '0;
      naverages_reg     <= '0;
      pass_reg          <= '0;
      idx_reg           <= '0;
      wr_pending_reg    <= 1'b0;
      wr_addr_reg       <= '0;
      wr_sample_reg     <= '0;
      wr_first_reg      <= 1'b0;
      wr_last_reg       <= 1'b0;
      rd_ptr_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      skid_valid_reg    <= 1'b0;
      skid_last_reg     <= 1'b0;
      skid_data_reg     <= '0;
      out_valid_reg     <= 1'b0;
      out_last_reg      <= 1'b0;
      out_data_reg      <= '0;
      done_reg          <= 1'b0;
    end else begin
      if (start_ok) begin
        nsamples_reg  <= nsamples;
        naverages_reg <= naverages;
        pass_reg      <= '0;
        idx_reg       <= '0;
        rd_ptr_reg    <= '0;
      end

      if (arm_hit)     idx_reg <= S_AXIS_tvalid ? IW'(1) : '0;
      else if (acc_en) idx_reg <= idx_reg + IW'(1);

      wr_pending_reg <= acc_en;
      wr_addr_reg    <= acc_addr;
      wr_sample_reg  <= S_AXIS_tdata;
      wr_first_reg   <= (pass_reg == '0);
      wr_last_reg    <= acc_last;

      if (pass_end) pass_reg <= pass_reg + CNT_WIDTH'(1);

      if (issue) rd_ptr_reg <= rd_ptr_reg + IW'(1);
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (rd_ptr_reg == nsamples_reg - IW'(1));

      // Ordered queue: out, then skid, then the word arriving from the RAM.
      if (!out_valid_reg || pop) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          out_last_reg   <= skid_last_reg;
          skid_valid_reg <= inflight_reg;
          skid_data_reg  <= rd_data_reg;
          skid_last_reg  <= inflight_last_reg;
        end else begin
          out_valid_reg <= inflight_reg;
          if (inflight_reg) begin
            out_data_reg <= rd_data_reg;
            out_last_reg <= inflight_last_reg;
          end
        end
      end else if (inflight_reg) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= rd_data_reg;
        skid_last_reg  <= inflight_last_reg;
      end

      done_reg <= start_noop || ((state_reg == S_DUMP) && pop && out_last_reg);
    end
  end
endmodule

// File: tb/tb_waveform_averager.sv
// Testbench for waveform_averager: directed and random runs checked against
// an element-wise summing reference model.
module tb_waveform_averager;
  logic        aclk = 1'b0;
  logic        rst;
  logic        start, trigger;
  logic [10:0] nsamples;
  logic [15:0] naverages;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        busy, done;

  waveform_averager dut (
    .aclk(aclk), .rst(rst), .start(start), .trigger(trigger),
    .nsamples(nsamples), .naverages(naverages),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .M_AXIS_tlast(m_tlast), .busy(busy), .done(done)
  );

  always #4 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge aclk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] samp [0:3][0:31];
  logic [31:0] got_q[$];
  logic        last_q[$];
  int          done_cnt = 0;
  int          first_v_cyc = -1;
  int          ready_pct = 100;
  bit          stall_prev = 0;
  logic [31:0] prev_data;

  // Downstream ready generator.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge aclk) begin
    if (stall_prev) begin
      chk("hold_valid", 32'(m_tvalid), 32'd1);
      chk("hold_data", m_tdata, prev_data);
    end
    stall_prev = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    if (m_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
    if (m_tvalid && m_tready) begin
      got_q.push_back(m_tdata);
      last_q.push_back(m_tlast);
      $display("out word %0d data=%h last=%0d", got_q.size() - 1, m_tdata, m_tlast);
    end
    if (done) done_cnt++;
  end

  task automatic run_avg(input int ns, input int na, input bit gappy,
                         input bit extra_trig, input int rdy);
    logic [31:0] exp_v [0:31];
    int i, wcyc, k;
    bit tog;
    for (int j = 0; j < ns; j++) begin
      exp_v[j] = 32'd0;
      for (int p = 0; p < na; p++) exp_v[j] = exp_v[j] + samp[p][j];
    end
    got_q.delete();
    last_q.delete();
    done_cnt    = 0;
    first_v_cyc = -1;
    ready_pct   = rdy;
    wcyc        = 0;
    nsamples  = 11'(ns);
    naverages = 16'(na);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int p = 0; p < na; p++) begin
      // Samples without a trigger while armed must be discarded.
      for (int j = 0; j < 2; j++) begin
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        tick();
      end
      trigger = 1'b1;
      if ($urandom_range(1) == 1) begin
        s_tvalid = 1'b1;
        s_tdata  = samp[p][0];
        i = 1;
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        i = 0;
      end
      tick();
      trigger = 1'b0;
      tog = 1'b1;
      while (i < ns) begin
        trigger  = extra_trig && (i == ns / 2);
        s_tvalid = gappy ? tog : 1'b1;
        tog      = ~tog;
        s_tdata  = s_tvalid ? samp[p][i] : $urandom;
        if (s_tvalid) i++;
        tick();
      end
      // Final write cycle: a trigger here must be ignored.
      wcyc     = cyc;
      trigger  = extra_trig;
      s_tvalid = 1'b0;
      tick();
      trigger = 1'b0;
      tick();
    end
    for (k = 0; k < 3000 && done_cnt == 0; k++) tick();
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    tick();
    tick();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("latency_ok", 32'((first_v_cyc >= 0) && (first_v_cyc - wcyc <= 3)), 32'd1);
    chk("word_count", 32'(got_q.size()), 32'(ns));
    for (int j = 0; j < ns && j < got_q.size(); j++) begin
      chk($sformatf("sum[%0d]", j), got_q[j], exp_v[j]);
      chk($sformatf("tlast[%0d]", j), 32'(last_q[j]), 32'(j == ns - 1));
    end
    $display("run ns=%0d na=%0d gappy=%0d trig=%0d rdy=%0d words=%0d", ns, na, gappy,
             extra_trig, rdy, got_q.size());
    ready_pct = 100;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; trigger = 1'b0;
    nsamples = '0; naverages = '0; s_tdata = '0; s_tvalid = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Single pass, signed samples.
    samp[0][0] = 32'd1; samp[0][1] = -32'sd2; samp[0][2] = 32'd3; samp[0][3] = -32'sd4;
    run_avg(4, 1, 0, 0, 100);

    // Three passes of 10,20,30,40.
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 4; j++) samp[p][j] = 32'(10 * (j + 1));
    run_avg(4, 3, 0, 0, 100);
    run_avg(4, 3, 1, 1, 100);

    // Backpressure with random ready.
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 8; j++) samp[p][j] = $urandom;
    run_avg(8, 2, 0, 0, 50);

    // Wrap-around of the two's complement sum.
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 2; j++) samp[p][j] = 32'h7FFF_FFFF;
    run_avg(2, 2, 0, 0, 100);

    // No-op start.
    nsamples = 11'd0; naverages = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("noop_done", 32'(done), 32'd1);
    chk("noop_busy", 32'(busy), 32'd0);
    tick();
    chk("noop_done_clr", 32'(done), 32'd0);
    done_cnt = 0;

    // Reset in the middle of acquisition.
    nsamples = 11'd8; naverages = 16'd2; start = 1'b1;
    tick();
    start = 1'b0; trigger = 1'b1; s_tvalid = 1'b1; s_tdata = 32'd100;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_tdata", m_tdata, 32'd0);
    rst = 1'b0;
    tick();
    samp[0][0] = 32'd5; samp[0][1] = 32'd6;
    run_avg(2, 1, 0, 0, 100);

    // Random runs.
    for (int r = 0; r < 5; r++) begin
      int ns, na;
      ns = $urandom_range(32, 1);
      na = $urandom_range(4, 1);
      for (int p = 0; p < 4; p++)
        for (int j = 0; j < 32; j++) samp[p][j] = $urandom;
      run_avg(ns, na, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(100, 30));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
